// File: rtl/countdown_pkg.sv
// Shared state encoding and constants for the BCD countdown controller.
package countdown_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [3:0]  BCD_MAX = 4'd9;
    localparam logic [15:0] LED_ALL = 16'hFFFF;

    // Out-of-range preset nibbles saturate to the largest BCD digit.
    function automatic logic [3:0] clamp_bcd(input logic [3:0] v);
        return (v > BCD_MAX) ? BCD_MAX : v;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the last count.
module tick_gen #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int              CW   = $clog2(TICK_DIV);
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Holding the count while disabled lets a paused step resume where it stopped.
    assign tick = en && (cnt_q == LAST);

endmodule

// File: rtl/countdown_ctrl.sv
// Two-digit BCD countdown sequencer: IDLE/RUN/PAUSE/DONE FSM, digit registers and display decode.
module countdown_ctrl
    import countdown_pkg::*;
#(
    parameter int         TICK_DIV  = 100_000_000,
    parameter logic [3:0] INIT_TENS = 4'd2,
    parameter logic [3:0] INIT_ONES = 4'd5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic [3:0]  preset_tens,
    input  logic [3:0]  preset_ones,
    output logic [3:0]  tens,
    output logic [3:0]  ones,
    output logic        running,
    output logic        done,
    output logic [15:0] led
);

    state_e     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic       tick;

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .en   (state_q == ST_RUN),
        .clr  (clear),
        .tick (tick)
    );

    always_comb begin
        state_d = state_q;
        tens_d  = tens_q;
        ones_d  = ones_q;
        if (clear) begin
            state_d = ST_IDLE;
            tens_d  = clamp_bcd(preset_tens);
            ones_d  = clamp_bcd(preset_ones);
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d = (tens_q == 4'd0 && ones_q == 4'd0) ? ST_DONE : ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (start) begin
                        state_d = ST_PAUSE;
                    end
                    // A tick coinciding with a pause still lands, so no step is lost.
                    if (tick) begin
                        if (ones_q != 4'd0) begin
                            ones_d = ones_q - 4'd1;
                            if (tens_q == 4'd0 && ones_q == 4'd1) begin
                                state_d = ST_DONE;
                            end
                        end else if (tens_q != 4'd0) begin
                            tens_d = tens_q - 4'd1;
                            ones_d = BCD_MAX;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tens_q  <= INIT_TENS;
            ones_q  <= INIT_ONES;
        end else begin
            state_q <= state_d;
            tens_q  <= tens_d;
            ones_q  <= ones_d;
        end
    end

    assign tens    = tens_q;
    assign ones    = ones_q;
    assign running = (state_q == ST_RUN);
    assign done    = (state_q == ST_DONE);
    assign led     = (state_q == ST_DONE) ? LED_ALL : 16'h0000;

endmodule
